// File: rtl/nvme_cmpl_pkg.sv
// Shared types and constants for the NVMe completion dispatcher and its arbiter.
// The record layout follows CMD_ACTION_ID_BITS / REQ_ID_BITS when the codebase defines them.
`ifndef CMD_ACTION_ID_BITS
`define CMD_ACTION_ID_BITS 4
`endif
`ifndef REQ_ID_BITS
`define REQ_ID_BITS 8
`endif

package nvme_cmpl_pkg;

    localparam int unsigned CMPL_ACT_BITS = `CMD_ACTION_ID_BITS;
    localparam int unsigned CMPL_SEQ_BITS = `REQ_ID_BITS;

    localparam int unsigned INFO_VALID_BIT = 0;
    localparam int unsigned INFO_ERR_BIT   = 1;

    typedef struct packed {
        logic [CMPL_ACT_BITS-1:0] action_id;
        logic                     error;
        logic [CMPL_SEQ_BITS-1:0] seq;
    } cmpl_rec_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StPush
    } disp_state_e;

endpackage

// File: rtl/nvme_rr_arb.sv
// Round-robin pick over N requesters: search starts at ptr_i+1 and wraps, ptr_i itself last.
// N must be a power of two so the index wraps naturally.
module nvme_rr_arb #(
    parameter int unsigned N       = 16,
    localparam int unsigned IdxBits = $clog2(N)
) (
    input  logic [N-1:0]       req_i,
    input  logic [IdxBits-1:0] ptr_i,
    output logic [IdxBits-1:0] gnt_o,
    output logic               found_o
);

    logic [IdxBits-1:0] idx;

    // Walk from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        idx     = '0;
        gnt_o   = '0;
        found_o = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = ptr_i + IdxBits'(k);
            if (req_i[idx]) begin
                gnt_o   = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvme_cmpl_dispatch.sv
// Round-robin completion dispatcher between the I/O completion tracker and the action interface.
// Optional per-action completion/error counters: define NVME_CMPL_DISPATCH_CNT_EN.
module nvme_cmpl_dispatch
    import nvme_cmpl_pkg::*;
#(
    parameter int unsigned ACT_BITS    = CMPL_ACT_BITS,
    parameter int unsigned INFO_BITS   = 2,
    parameter int unsigned SEQ_BITS    = CMPL_SEQ_BITS,
    parameter int unsigned TIMEOUT_CYC = 15,
    localparam int unsigned NACT       = 2 ** ACT_BITS
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic                 track_init,
    input  logic [NACT-1:0]      track_status,
    output logic                 track_update,
    output logic [ACT_BITS-1:0]  track_update_id,
    input  logic                 track_update_done,
    input  logic [INFO_BITS-1:0] track_update_data,
    input  logic [NACT-1:0]      act_enable,
    output logic                 cmpl_valid,
    input  logic                 cmpl_ready,
    output logic [ACT_BITS-1:0]  cmpl_action_id,
    output logic                 cmpl_error,
    output logic [SEQ_BITS-1:0]  cmpl_seq,
    output logic                 proto_error,
`ifdef NVME_CMPL_DISPATCH_CNT_EN
    input  logic [ACT_BITS-1:0]  cnt_sel,
    output logic [31:0]          cnt_cmpl,
    output logic [31:0]          cnt_err,
`endif
    input  logic                 proto_error_clear
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    disp_state_e         state_q, state_d;
    logic [ACT_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [ACT_BITS-1:0] upd_id_q, upd_id_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    cmpl_rec_t           rec_q, rec_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic [SEQ_BITS-1:0] seq_q [NACT];
    logic                seq_inc;
    logic                perr_set;
    logic [ACT_BITS-1:0] arb_id;
    logic                arb_found;

    nvme_rr_arb #(
        .N (NACT)
    ) u_arb (
        .req_i   (track_status & act_enable),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_id),
        .found_o (arb_found)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        upd_id_d = upd_id_q;
        tmo_d    = tmo_q;
        rec_d    = rec_q;
        valid_d  = valid_q;
        seq_inc  = 1'b0;
        perr_set = 1'b0;
        if (!track_init) begin
            // Tracker re-init aborts any transaction in flight.
            state_d = StIdle;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_found) begin
                        upd_id_d = arb_id;
                        state_d  = StIssue;
                    end
                end
                StIssue: begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (track_update_done) begin
                        rr_ptr_d = upd_id_q;
                        if (track_update_data[INFO_VALID_BIT]) begin
                            rec_d.action_id = upd_id_q;
                            rec_d.error     = track_update_data[INFO_ERR_BIT];
                            rec_d.seq       = seq_q[upd_id_q];
                            valid_d         = 1'b1;
                            seq_inc         = 1'b1;
                            state_d         = StPush;
                        end else begin
                            perr_set = 1'b1;
                            state_d  = StIdle;
                        end
                    end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                        perr_set = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
                StPush: begin
                    if (cmpl_ready) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        perr_d = perr_set | (perr_q & ~proto_error_clear);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            upd_id_q <= '0;
            tmo_q    <= '0;
            rec_q    <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            upd_id_q <= upd_id_d;
            tmo_q    <= tmo_d;
            rec_q    <= rec_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NACT; i++) seq_q[i] <= '0;
        end else if (!track_init) begin
            for (int i = 0; i < NACT; i++) seq_q[i] <= '0;
        end else if (seq_inc) begin
            seq_q[upd_id_q] <= seq_q[upd_id_q] + SEQ_BITS'(1);
        end
    end

    assign track_update    = (state_q == StIssue);
    assign track_update_id = upd_id_q;
    assign cmpl_valid      = valid_q;
    assign cmpl_action_id  = rec_q.action_id;
    assign cmpl_error      = rec_q.error;
    assign cmpl_seq        = rec_q.seq;
    assign proto_error     = perr_q;

`ifdef NVME_CMPL_DISPATCH_CNT_EN
    logic [31:0] cnt_cmpl_q [NACT];
    logic [31:0] cnt_err_q  [NACT];
    logic [31:0] cnt_cmpl_rd_q, cnt_err_rd_q;
    logic        cnt_hit;

    assign cnt_hit = valid_q && cmpl_ready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NACT; i++) begin
                cnt_cmpl_q[i] <= '0;
                cnt_err_q[i]  <= '0;
            end
            cnt_cmpl_rd_q <= '0;
            cnt_err_rd_q  <= '0;
        end else begin
            if (!track_init) begin
                for (int i = 0; i < NACT; i++) begin
                    cnt_cmpl_q[i] <= '0;
                    cnt_err_q[i]  <= '0;
                end
            end else if (cnt_hit) begin
                if (cnt_cmpl_q[rec_q.action_id] != '1) begin
                    cnt_cmpl_q[rec_q.action_id] <= cnt_cmpl_q[rec_q.action_id] + 32'd1;
                end
                if (rec_q.error && cnt_err_q[rec_q.action_id] != '1) begin
                    cnt_err_q[rec_q.action_id] <= cnt_err_q[rec_q.action_id] + 32'd1;
                end
            end
            cnt_cmpl_rd_q <= cnt_cmpl_q[cnt_sel];
            cnt_err_rd_q  <= cnt_err_q[cnt_sel];
        end
    end

    assign cnt_cmpl = cnt_cmpl_rd_q;
    assign cnt_err  = cnt_err_rd_q;
`endif

endmodule

// File: doc/nvme_cmpl_dispatch.md
Name: nvme_cmpl_dispatch

Overview:
- Downstream consumer of the per-action I/O completion tracker.
- Watches the tracker's per-action ready bitmap and round-robins over enabled actions.
- For each grant: issues the single-cycle update request, captures returned tracking info, and emits one completion record per retired command on a valid/ready stream towards the action interface.
- Per-action ordering is guaranteed by the tracker; fairness across actions is guaranteed here.

Parameters:
- ACT_BITS, default `CMD_ACTION_ID_BITS (4): action id width; NACT = 2**ACT_BITS.
- INFO_BITS, default 2: tracking info width; bit0 = entry valid, bit1 = NVMe status non-zero.
- SEQ_BITS, default `REQ_ID_BITS (8): per-action completion sequence counter width.
- TIMEOUT_CYC, default 15: maximum cycles from update request to done before a protocol error is flagged.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  async active-low reset
- track_init  in  1  tracker memory cleared; block idles while low
- track_status  in  NACT  per-action "next in-order completion present"
- track_update  out  1  single-cycle update request
- track_update_id  out  ACT_BITS  action being retired; held stable until done
- track_update_done  in  1  update finished
- track_update_data  in  INFO_BITS  retired entry info
- act_enable  in  NACT  per-action dispatch enable
- cmpl_valid  out  1  completion record valid
- cmpl_ready  in  1  consumer accept
- cmpl_action_id  out  ACT_BITS  action of record
- cmpl_error  out  1  command completed with error status
- cmpl_seq  out  SEQ_BITS  per-action completion sequence number
- proto_error  out  1  sticky: done timeout, or done with data bit0=0 after a granted status
- proto_error_clear  in  1  clears proto_error

Behaviour:
- Reset (async, axi_aresetn low): all outputs 0; FSM in IDLE; RR pointer 0; all seq counters 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, PUSH.
  - IDLE: while track_init=0, stay. Otherwise form req = track_status & act_enable. If req==0, stay. Else grant the first set bit searching from rr_ptr+1 upward, wrapping modulo NACT (rr_ptr itself is searched last); latch the grant into track_update_id; go to ISSUE.
  - ISSUE: assert track_update for exactly one cycle; clear timeout counter; go to WAIT.
  - WAIT: hold track_update_id. On track_update_done:
    - If data[0]=1: load cmpl_action_id=id, cmpl_error=data[1], cmpl_seq=seq[id]; set cmpl_valid; increment seq[id] with wrap at 2**SEQ_BITS; set rr_ptr=id; go to PUSH.
    - If data[0]=0: set proto_error, set rr_ptr=id, go to IDLE. No record is emitted.
    - If done has not arrived after TIMEOUT_CYC cycles: set proto_error and go to IDLE.
  - PUSH: cmpl_valid and its fields stay stable until cmpl_ready. On the accept cycle, deassert cmpl_valid and go to IDLE.
- Latency: grant to track_update is 1 cycle; done to cmpl_valid is 1 cycle.
- Throughput: at most one completion per 4 cycles plus tracker latency (3 cycles), assuming cmpl_ready is held high.
- track_status is re-sampled only in IDLE, at least one cycle after done. The tracker updates status on the same edge as done, so no stale double-grant is possible.
- act_enable deasserted mid-operation: the in-flight update completes and is pushed; the action is excluded only from subsequent grants.
- Single requester: grants the same action repeatedly; it is still fair because rr_ptr advances to the granted id.
- proto_error_clear and a new error in the same cycle: the error wins (flag stays 1).
- track_init falling mid-operation (tracker re-init): abort to IDLE, drop cmpl_valid, reset seq counters.

Optional Feature:
- NVME_CMPL_DISPATCH_CNT_EN
  - Defined: adds per-action 32-bit saturating counters for completions and for errors. Readback ports: cnt_sel (ACT_BITS, in), cnt_cmpl (32, out), cnt_err (32, out), registered with 1-cycle latency. A counter increments on the cmpl_valid&&cmpl_ready accept cycle. Counters clear on reset and on track_init falling.
  - Undefined: these ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package nvme_cmpl_pkg:
  - typedef cmpl_rec_t {action_id, error, seq}.
  - Constants INFO_VALID_BIT=0 and INFO_ERR_BIT=1.
  - FSM state enum.
- Sub-module nvme_rr_arb (NACT-wide round-robin priority pick from a pointer, combinational plus found flag). It is reused by submission-side arbitration.

Test Plan:
- Reset/init: track_init=0 with track_status=16'h00FF → track_update never asserted. Raise track_init → first grant id 1 (search starts at rr_ptr+1 = 1).
- Round robin: status=16'h0005 held, enable all, done after 3 cycles with data=2'b01, ready=1 → cmpl_action_id sequence 2,0,2,0; each cmpl_seq per action counts 0,1,2.
- Error status: data=2'b11 on action 7 → cmpl_error=1, cmpl_action_id=7, proto_error=0.
- Backpressure: cmpl_ready=0 for 10 cycles → cmpl_valid and fields stable, no new track_update. ready=1 → accept, next grant follows.
- Protocol faults: done withheld 15 cycles → proto_error=1, FSM back to IDLE. Done with data=2'b00 → proto_error=1, no record. proto_error_clear → 0.
- Seq wrap / mask: 256 completions on action 3 → cmpl_seq wraps 255→0. act_enable[3]=0 with status[3]=1 → no grant to 3.
